// File: rtl/im_boot_loader_pkg.sv
// ---------------------------------------------------------------------------
// im_boot_loader_pkg
// Shared types and constants for the instruction-memory boot loader:
//   loader_state_e  - loader FSM states
//   WEB_ALL_WR      - SRAM byte write enables, all four lanes written
//   WEB_NONE        - SRAM byte write enables, no lane written
//   BYTES_PER_WORD  - stream bytes packed into one 32-bit IM word
// ---------------------------------------------------------------------------
package im_boot_loader_pkg;

    typedef enum logic [2:0] {
        HDR,
        LOAD,
        WR,
        VRD,
        VCMP,
        DONE,
        ERR
    } loader_state_e;

    localparam logic [3:0] WEB_ALL_WR     = 4'b0000;
    localparam logic [3:0] WEB_NONE       = 4'b1111;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_boot_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// im_boot_loader_byte_packer
// Packs an accepted byte stream into little-endian 32-bit words.
//   clk, rst     - clock, asynchronous active-high reset
//   clear        - restart packing at byte 0 of a word
//   byte_valid   - a byte is transferred this cycle (already qualified)
//   byte_data    - the transferred byte
//   word         - packed word, complete in the cycle after word_last
//   word_nxt     - word as it will be after this cycle's byte is shifted in
//   word_last    - this cycle's byte completes a word (combinational)
//   word_valid   - one-cycle pulse while word holds a freshly completed word
// ---------------------------------------------------------------------------
module im_boot_loader_byte_packer
    import im_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic [31:0] word_nxt,
    output logic        word_last,
    output logic        word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0] byte_cnt;

    // New bytes enter at the top, so after four bytes the first one sits in [7:0].
    assign word_nxt  = {byte_data, word[31:8]};
    assign word_last = byte_valid && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_last;
            if (clear) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid) begin
            word <= word_nxt;
        end
    end

endmodule

// File: rtl/im_boot_loader.sv
// ---------------------------------------------------------------------------
// im_boot_loader
// Writer side of the instruction-memory SRAM port. Receives a byte stream
// (4-byte LE word count N, then N LE words), writes the words to consecutive
// IM addresses from BASE_ADDR, optionally re-reads them and compares a 32-bit
// sum, and keeps the CPU in reset until the load has completed.
//   clk       - system clock (SRAM runs on ~clk)
//   rst       - asynchronous active-high reset
//   in_valid  - byte available on in_data
//   in_data   - stream byte
//   in_ready  - byte accepted this cycle when in_valid is also high
//   sram_cs   - SRAM chip select
//   sram_oe   - SRAM output enable
//   sram_web  - SRAM byte write enables, active low
//   sram_a    - SRAM word address
//   sram_di   - SRAM write data
//   sram_do   - SRAM read data, valid at the rising edge after its address
//   cpu_hold  - 1 keeps the CPU in reset and the IM port owned by the loader
//   done      - load (and verify) finished, sticky
//   error     - length overflow or checksum mismatch, sticky
// All outputs are registered; the register inputs are derived from the next
// state so that the pins always describe the state the FSM is in.
// ---------------------------------------------------------------------------
module im_boot_loader
    import im_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0,
    parameter bit VERIFY    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [3:0]        sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [31:0]       sram_di,
    input  logic [31:0]       sram_do,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Largest word count that still fits between BASE_ADDR and the top of memory.
    localparam logic [32:0]       MAX_N = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    loader_state_e     state, state_d;
    logic [ADDR_W:0]   idx, idx_d, idx_inc;
    logic [ADDR_W:0]   n_cnt, n_d;
    logic [31:0]       sum_wr, sum_wr_d;
    logic [31:0]       sum_rd, sum_rd_total;
    logic [31:0]       rd_data_p1;
    logic              vld_p1;

    logic              cs_d, oe_d;
    logic [3:0]        web_d;
    logic [ADDR_W-1:0] a_d;
    logic [31:0]       di_d;

    logic              take;
    logic              pk_clear;
    logic [31:0]       word, word_nxt;
    logic              word_last, word_valid;

    assign take     = in_valid && in_ready;
    assign pk_clear = (state == DONE) || (state == ERR);
    assign idx_inc  = idx + 1'b1;

    im_boot_loader_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (take),
        .byte_data  (in_data),
        .word       (word),
        .word_nxt   (word_nxt),
        .word_last  (word_last),
        .word_valid (word_valid)
    );

    // The last read word is still in the capture register during VCMP, so fold it in here.
    assign sum_rd_total = wrap_add(sum_rd, vld_p1 ? rd_data_p1 : 32'd0);

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        n_d      = n_cnt;
        sum_wr_d = sum_wr;
        cs_d     = 1'b0;
        oe_d     = 1'b0;
        web_d    = WEB_NONE;
        a_d      = sram_a;
        di_d     = sram_di;
        unique case (state)
            HDR: begin
                if (word_last) begin
                    idx_d = '0;
                    if (word_nxt == 32'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, word_nxt} > MAX_N) begin
                        state_d = ERR;
                    end else begin
                        n_d     = word_nxt[ADDR_W:0];
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (word_last) begin
                    state_d = WR;
                    cs_d    = 1'b1;
                    web_d   = WEB_ALL_WR;
                    a_d     = BASE + idx[ADDR_W-1:0];
                    di_d    = word_nxt;
                end
            end
            WR: begin
                if (word_valid) begin
                    sum_wr_d = wrap_add(sum_wr, word);
                end
                idx_d = idx_inc;
                if (idx_inc == n_cnt) begin
                    if (VERIFY) begin
                        // First read address goes out together with the entry into VRD.
                        state_d = VRD;
                        idx_d   = {{ADDR_W{1'b0}}, 1'b1};
                        cs_d    = 1'b1;
                        oe_d    = 1'b1;
                        a_d     = BASE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            VRD: begin
                // idx counts read addresses already issued.
                if (idx == n_cnt) begin
                    state_d = VCMP;
                end else begin
                    cs_d  = 1'b1;
                    oe_d  = 1'b1;
                    a_d   = BASE + idx[ADDR_W-1:0];
                    idx_d = idx_inc;
                end
            end
            VCMP: begin
                state_d = (sum_rd_total == sum_wr) ? DONE : ERR;
            end
            DONE: state_d = DONE;
            ERR:  state_d = ERR;
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HDR;
            idx      <= '0;
            n_cnt    <= '0;
            sum_wr   <= '0;
            sum_rd   <= '0;
            vld_p1   <= 1'b0;
            in_ready <= 1'b0;
            sram_cs  <= 1'b0;
            sram_oe  <= 1'b0;
            sram_web <= WEB_NONE;
            sram_a   <= '0;
            sram_di  <= '0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            n_cnt    <= n_d;
            sum_wr   <= sum_wr_d;
            // Read data stage: every VRD cycle has an address on the pins.
            vld_p1   <= (state == VRD);
            if (vld_p1) begin
                sum_rd <= wrap_add(sum_rd, rd_data_p1);
            end
            in_ready <= (state_d == HDR) || (state_d == LOAD);
            sram_cs  <= cs_d;
            sram_oe  <= oe_d;
            sram_web <= web_d;
            sram_a   <= a_d;
            sram_di  <= di_d;
            cpu_hold <= (state_d != DONE);
            done     <= (state_d == DONE);
            error    <= (state_d == ERR);
        end
    end

    always_ff @(posedge clk) begin
        rd_data_p1 <= sram_do;
    end

endmodule

// File: tb/tb_im_boot_loader.sv
module tb_im_boot_loader;

    localparam int ADDR_W    = 14;
    localparam int BASE_ADDR = 0;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              sram_cs;
    logic              sram_oe;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [31:0]       sram_di;
    logic [31:0]       sram_do;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int checks;
    int failures;

    im_boot_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .VERIFY    (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sram_cs  (sram_cs),
        .sram_oe  (sram_oe),
        .sram_web (sram_web),
        .sram_a   (sram_a),
        .sram_di  (sram_di),
        .sram_do  (sram_do),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model clocked on ~clk plus activity counters (cumulative, only written here).
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] wr_tmp;
    bit          corrupt_en;
    int          corrupt_addr;
    int          wr_cycles, cs_cycles, rd_cycles, rdy_viol, both_viol;

    always @(negedge clk) begin
        if (sram_cs) cs_cycles++;
        if (sram_cs && sram_web != 4'hF) begin
            wr_cycles++;
            if (in_ready) rdy_viol++;
            wr_tmp = mem[sram_a];
            for (int k = 0; k < 4; k++)
                if (!sram_web[k]) wr_tmp[8*k +: 8] = sram_di[8*k +: 8];
            mem[sram_a] <= wr_tmp;
        end
        if (sram_cs && sram_oe) begin
            rd_cycles++;
            sram_do <= (corrupt_en && int'(sram_a) == corrupt_addr) ? (mem[sram_a] ^ 32'h1) : mem[sram_a];
        end
        if (done && error) both_viol++;
    end

    // Reference model: the words of the current stream and the expected outcome.
    logic [31:0] stim_q [$];

    function automatic bit model_error(input longint unsigned n, input bit corrupt, input int caddr);
        if (n > longint'(DEPTH - BASE_ADDR)) return 1'b1;
        if (corrupt && caddr >= BASE_ADDR && longint'(caddr - BASE_ADDR) < longint'(n)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_stream(input logic [31:0] n, input bit gap);
        send_word(n, gap);
        foreach (stim_q[i]) send_word(stim_q[i], gap);
    endtask

    task automatic wait_end(input string name);
        int t;
        t = 0;
        while (!(done || error) && t < 500) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (!(done || error)) begin
            failures++;
            $display("FAIL %s_timeout done=%0b error=%0b required one of them 1", name, done, error);
        end
    endtask

    task automatic check_image(input string name);
        foreach (stim_q[i]) begin
            checks++;
            if (mem[BASE_ADDR + i] !== stim_q[i]) begin
                failures++;
                $display("FAIL %s_image addr=%0d got=%h required=%h", name, BASE_ADDR + i, mem[BASE_ADDR + i], stim_q[i]);
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0b required=%0b", name, got, req);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        // Get into the middle of a header, then assert reset asynchronously.
        send_byte(8'h05);
        send_byte(8'h00);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_bit("reset_in_ready", in_ready, 1'b0);
        check_bit("reset_cs", sram_cs, 1'b0);
        check_bit("reset_oe", sram_oe, 1'b0);
        checks++;
        if (sram_web !== 4'b1111) begin
            failures++;
            $display("FAIL reset_web got=%b required=1111", sram_web);
        end
        check_int("reset_a", int'(sram_a), 0);
        checks++;
        if (sram_di !== 32'h0) begin
            failures++;
            $display("FAIL reset_di got=%h required=00000000", sram_di);
        end
        check_bit("reset_cpu_hold", cpu_hold, 1'b1);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_error", error, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int w0, r0;
        apply_reset();
        stim_q = {32'h11223344, 32'hDEADBEEF};
        w0 = wr_cycles;
        r0 = rd_cycles;
        send_stream(32'd2, 1'b0);
        wait_end("basic");
        check_image("basic");
        check_int("basic_write_cycles", wr_cycles - w0, 2);
        check_int("basic_read_cycles", rd_cycles - r0, 2);
        check_bit("basic_done", done, 1'b1);
        check_bit("basic_error", error, 1'b0);
        check_bit("basic_cpu_hold", cpu_hold, 1'b0);
        check_bit("basic_in_ready", in_ready, 1'b0);
    endtask

    task automatic test_zero_len();
        int c0;
        apply_reset();
        stim_q = {};
        c0 = cs_cycles;
        send_word(32'd0, 1'b0);
        check_bit("zero_done_next_cycle", done, 1'b1);
        repeat (4) @(negedge clk);
        check_int("zero_cs_cycles", cs_cycles - c0, 0);
        check_bit("zero_cpu_hold", cpu_hold, 1'b0);
        check_bit("zero_error", error, 1'b0);
    endtask

    task automatic test_overflow();
        int w0;
        apply_reset();
        w0 = wr_cycles;
        send_word(32'(DEPTH - BASE_ADDR + 1), 1'b0);
        repeat (4) @(negedge clk);
        check_bit("ovf_error", error, model_error(longint'(DEPTH - BASE_ADDR + 1), 1'b0, 0));
        check_bit("ovf_done", done, 1'b0);
        check_bit("ovf_cpu_hold", cpu_hold, 1'b1);
        check_bit("ovf_in_ready", in_ready, 1'b0);
        check_int("ovf_write_cycles", wr_cycles - w0, 0);
    endtask

    task automatic test_corrupt_verify();
        apply_reset();
        stim_q = {$urandom, $urandom};
        corrupt_addr = 1;
        corrupt_en   = 1'b1;
        send_stream(32'd2, 1'b0);
        wait_end("corrupt");
        corrupt_en = 1'b0;
        check_image("corrupt");
        check_bit("corrupt_error", error, model_error(2, 1'b1, 1));
        check_bit("corrupt_done", done, 1'b0);
        check_bit("corrupt_cpu_hold", cpu_hold, 1'b1);
    endtask

    task automatic test_toggle_valid();
        int w0, v0;
        apply_reset();
        stim_q = {$urandom, $urandom, $urandom};
        w0 = wr_cycles;
        v0 = rdy_viol;
        send_stream(32'd3, 1'b1);
        wait_end("toggle");
        check_image("toggle");
        check_int("toggle_write_cycles", wr_cycles - w0, 3);
        check_int("toggle_in_ready_in_wr", rdy_viol - v0, 0);
        check_bit("toggle_done", done, 1'b1);
    endtask

    task automatic test_mid_reset();
        int w0;
        logic [31:0] first;
        apply_reset();
        first = $urandom;
        send_word(32'd2, 1'b0);
        send_byte(first[7:0]);
        send_byte(first[15:8]);
        apply_reset();
        stim_q = {32'hCAFEF00D};
        w0 = wr_cycles;
        send_stream(32'd1, 1'b0);
        wait_end("midrst");
        check_image("midrst");
        check_int("midrst_write_cycles", wr_cycles - w0, 1);
        check_bit("midrst_done", done, 1'b1);
    endtask

    task automatic test_random_streams();
        for (int r = 0; r < 6; r++) begin
            int unsigned n;
            bit gap, corrupt;
            int caddr, v0;
            n       = $urandom_range(1, 7);
            gap     = 1'($urandom_range(0, 1));
            corrupt = ($urandom_range(0, 2) == 0);
            caddr   = BASE_ADDR + int'($urandom_range(0, n - 1));
            stim_q  = {};
            for (int i = 0; i < int'(n); i++) stim_q.push_back($urandom);
            apply_reset();
            corrupt_addr = caddr;
            corrupt_en   = corrupt;
            v0 = rdy_viol;
            send_stream(32'(n), gap);
            wait_end("rand");
            corrupt_en = 1'b0;
            check_image("rand");
            check_bit("rand_error", error, model_error(longint'(n), corrupt, caddr));
            check_bit("rand_done", done, !model_error(longint'(n), corrupt, caddr));
            check_int("rand_in_ready_in_wr", rdy_viol - v0, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        corrupt_en   = 1'b0;
        corrupt_addr = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_corrupt_verify();
        test_toggle_valid();
        test_mid_reset();
        test_random_streams();
        check_int("done_and_error_together", both_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
